// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
// Generates a periodic sample tick and, on each tick, captures both ZmodADC1410
// channel words and streams a 6-byte frame (sync, status, CH1 H/L, CH2 H/L)
// through the byte-serial transmitter's send/ready handshake.
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous reset, active low
//   i_enable       tick generation enable (level)
//   i_ch1_data     channel 1 sample word
//   i_ch2_data     channel 2 sample word
//   i_ch1_empty    channel 1 FIFO empty (sample invalid)
//   i_ch2_empty    channel 2 FIFO empty (sample invalid)
//   i_ready        serial transmitter idle / ready
//   o_send         one-cycle byte-send strobe
//   o_data         byte presented to the transmitter
//   o_busy         frame in progress
//   o_overrun      sticky: tick arrived while a frame was in progress
//   o_frame_count  completed frames, wrapping
module adc_frame_scheduler #(
   parameter int unsigned          DATA_SIZE    = 16,
   parameter int unsigned          BYTE_SIZE    = 8,
   parameter int unsigned          PERIOD_COUNT = 31000000,
   parameter logic [BYTE_SIZE-1:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [DATA_SIZE-1:0] i_ch1_data,
   input  logic [DATA_SIZE-1:0] i_ch2_data,
   input  logic                 i_ch1_empty,
   input  logic                 i_ch2_empty,
   input  logic                 i_ready,
   output logic                 o_send,
   output logic [BYTE_SIZE-1:0] o_data,
   output logic                 o_busy,
   output logic                 o_overrun,
   output logic [15:0]          o_frame_count
);

   localparam int unsigned      CNT_W    = $clog2(PERIOD_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_COUNT - 1);
   localparam logic [2:0]       LAST_IDX = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_SEND,
      S_ACK,
      S_NEXT
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     period_cnt;
   logic                 tick;
   logic [2:0]           index;
   logic [DATA_SIZE-1:0] ch1_q;
   logic [DATA_SIZE-1:0] ch2_q;
   logic                 v1;
   logic                 v2;
   logic                 overrun;
   logic [15:0]          frame_count;
   logic [BYTE_SIZE-1:0] frame_byte;

   // Period counter: held at zero while disabled, so enabling always yields
   // the first tick a full period later.
   assign tick = i_enable && (period_cnt == CNT_LAST);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         period_cnt <= '0;
      end else if (!i_enable || tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + CNT_W'(1);
      end
   end

   // Any tick seen outside IDLE is dropped and flagged; this includes a tick
   // coincident with the final NEXT of a frame.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         overrun <= 1'b0;
      end else if (!i_enable) begin
         overrun <= 1'b0;
      end else if (tick && (state != S_IDLE)) begin
         overrun <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      o_send     = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_next = S_SEND;
         end
         S_SEND: begin
            if (i_ready) begin
               o_send     = 1'b1;
               state_next = S_ACK;
            end
         end
         S_ACK: begin
            // i_ready falling is the transmitter's acceptance of the byte.
            if (!i_ready) state_next = S_NEXT;
         end
         S_NEXT: begin
            state_next = (index == LAST_IDX) ? S_IDLE : S_SEND;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= S_IDLE;
         index       <= '0;
         ch1_q       <= '0;
         ch2_q       <= '0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         frame_count <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_CAPTURE: begin
               ch1_q <= i_ch1_data;
               ch2_q <= i_ch2_data;
               v1    <= ~i_ch1_empty;
               v2    <= ~i_ch2_empty;
               index <= '0;
            end
            S_NEXT: begin
               if (index == LAST_IDX) begin
                  frame_count <= frame_count + 16'd1;
               end else begin
                  index <= index + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Invalid channels transmit zeros in place of their sample bytes.
   always_comb begin
      frame_byte = '0;
      case (index)
         3'd0: frame_byte = SYNC_BYTE;
         3'd1: frame_byte = {frame_count[5:0], v2, v1};
         3'd2: frame_byte = v1 ? ch1_q[15:8] : '0;
         3'd3: frame_byte = v1 ? ch1_q[7:0]  : '0;
         3'd4: frame_byte = v2 ? ch2_q[15:8] : '0;
         3'd5: frame_byte = v2 ? ch2_q[7:0]  : '0;
         default: frame_byte = '0;
      endcase
   end

   assign o_data        = ((state == S_SEND) || (state == S_ACK)) ? frame_byte : '0;
   assign o_busy        = (state != S_IDLE);
   assign o_overrun     = overrun;
   assign o_frame_count = frame_count;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler
// Directed bench for adc_frame_scheduler with a byte-serial transmitter model.
// Expected frame bytes are queued when each frame is launched; a monitor pops
// and compares them whenever the DUT strobes o_send.
module tb_adc_frame_scheduler;

   localparam int unsigned PERIOD = 20;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_enable = 1'b0;
   logic [15:0] i_ch1_data = '0;
   logic [15:0] i_ch2_data = '0;
   logic        i_ch1_empty = 1'b0;
   logic        i_ch2_empty = 1'b0;
   logic        i_ready;
   logic        o_send;
   logic [7:0]  o_data;
   logic        o_busy;
   logic        o_overrun;
   logic [15:0] o_frame_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] exp_fc = '0;

   logic        ser_ready = 1'b1;
   logic        stall = 1'b0;
   int          ser_gap = 10;
   int          ser_cnt = 0;
   logic        ser_sent;
   logic        prev_send = 1'b0;
   logic [7:0]  exp_byte;

   adc_frame_scheduler #(
      .DATA_SIZE    (16),
      .BYTE_SIZE    (8),
      .PERIOD_COUNT (PERIOD),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_ch1_data    (i_ch1_data),
      .i_ch2_data    (i_ch2_data),
      .i_ch1_empty   (i_ch1_empty),
      .i_ch2_empty   (i_ch2_empty),
      .i_ready       (i_ready),
      .o_send        (o_send),
      .o_data        (o_data),
      .o_busy        (o_busy),
      .o_overrun     (o_overrun),
      .o_frame_count (o_frame_count)
   );

   always #5 i_clock = ~i_clock;

   assign i_ready = ser_ready & ~stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Transmitter model: ready falls the cycle after a send and returns
   // ser_gap cycles later. Updates land 1 time unit after posedge.
   always begin
      @(negedge i_clock);
      ser_sent = o_send;
      @(posedge i_clock);
      #1;
      if (ser_sent) begin
         ser_ready = 1'b0;
         ser_cnt   = ser_gap;
      end else if (!ser_ready) begin
         ser_cnt--;
         if (ser_cnt <= 0) ser_ready = 1'b1;
      end
   end

   // Scoreboard monitor.
   always @(negedge i_clock) begin
      if (o_send) begin
         check("send_back_to_back", {31'd0, prev_send}, 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_send: got byte %0h, expected no send", o_data);
         end else begin
            exp_byte = exp_q.pop_front();
            check("frame_byte", {24'd0, o_data}, {24'd0, exp_byte});
         end
      end
      prev_send = o_send;
   end

   task automatic push6(input logic [7:0] b0, b1, b2, b3, b4, b5);
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      exp_q.push_back(b3);
      exp_q.push_back(b4);
      exp_q.push_back(b5);
   endtask

   task automatic wait_busy(input logic level, input int budget, input string name);
      int n = 0;
      while (o_busy !== level && n < budget) begin
         @(negedge i_clock);
         n++;
      end
      check(name, {31'd0, o_busy}, {31'd0, level});
   endtask

   // Launch a single frame: enable until it starts, then let it complete.
   task automatic run_frame(input logic [15:0] c1, c2, input logic e1, e2);
      @(negedge i_clock);
      i_ch1_data  = c1;
      i_ch2_data  = c2;
      i_ch1_empty = e1;
      i_ch2_empty = e2;
      i_enable    = 1'b1;
      wait_busy(1'b1, 100, "frame_start");
      i_enable = 1'b0;
      wait_busy(1'b0, 4000, "frame_done");
      exp_fc++;
      check("frame_count", {16'd0, o_frame_count}, {16'd0, exp_fc});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sends;
      int bad;

      // Reset state
      #1 i_reset = 1'b0;
      #3;
      check("rst_send",    {31'd0, o_send},    32'd0);
      check("rst_data",    {24'd0, o_data},    32'd0);
      check("rst_busy",    {31'd0, o_busy},    32'd0);
      check("rst_overrun", {31'd0, o_overrun}, 32'd0);
      check("rst_fcount",  {16'd0, o_frame_count}, 32'd0);
      repeat (3) @(negedge i_clock);
      i_reset = 1'b1;

      // Basic frame with tick latency
      @(negedge i_clock);
      i_ch1_data  = 16'h1234;
      i_ch2_data  = 16'hABCD;
      i_ch1_empty = 1'b0;
      i_ch2_empty = 1'b0;
      push6(8'hA5, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD);
      i_enable = 1'b1;
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (!o_busy && n < 100);
      check("enable_to_capture_cycles", n, 20);
      @(negedge i_clock);
      check("first_send_latency", {31'd0, o_send}, 32'd1);
      i_enable = 1'b0;
      wait_busy(1'b0, 4000, "frame_done");
      exp_fc++;
      check("frame_count", {16'd0, o_frame_count}, {16'd0, exp_fc});
      check("no_overrun_basic", {31'd0, o_overrun}, 32'd0);

      // Invalid channel 2
      push6(8'hA5, 8'h05, 8'h00, 8'hFF, 8'h00, 8'h00);
      run_frame(16'h00FF, 16'hABCD, 1'b0, 1'b1);

      // Stall in SEND
      @(posedge i_clock);
      #1 stall = 1'b1;
      @(negedge i_clock);
      i_ch1_data  = 16'h0102;
      i_ch2_data  = 16'h0304;
      i_ch2_empty = 1'b0;
      push6(8'hA5, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h04);
      i_enable = 1'b1;
      wait_busy(1'b1, 100, "stall_start");
      i_enable = 1'b0;
      sends = 0;
      bad   = 0;
      repeat (500) begin
         @(negedge i_clock);
         if (o_send) sends++;
         if (o_data !== 8'hA5) bad++;
      end
      check("stall_sends", sends, 0);
      check("stall_data_changes", bad, 0);
      check("stall_busy", {31'd0, o_busy}, 32'd1);
      @(posedge i_clock);
      #1 stall = 1'b0;
      wait_busy(1'b0, 4000, "stall_done");
      exp_fc++;
      check("frame_count", {16'd0, o_frame_count}, {16'd0, exp_fc});

      // Sample stability: inputs churn every cycle after capture
      @(negedge i_clock);
      i_ch1_data = 16'h5A5A;
      i_ch2_data = 16'hC3C3;
      push6(8'hA5, 8'h0F, 8'h5A, 8'h5A, 8'hC3, 8'hC3);
      i_enable = 1'b1;
      wait_busy(1'b1, 100, "churn_start");
      i_enable = 1'b0;
      n = 0;
      do begin
         @(negedge i_clock);
         i_ch1_data = 16'($urandom);
         i_ch2_data = 16'($urandom);
         n++;
      end while (o_busy && n < 4000);
      check("churn_done", {31'd0, o_busy}, 32'd0);
      exp_fc++;
      check("frame_count", {16'd0, o_frame_count}, {16'd0, exp_fc});

      // Overrun: slow transmitter, enable left high across a second tick
      ser_gap = 40;
      @(negedge i_clock);
      i_ch1_data = 16'h1111;
      i_ch2_data = 16'h2222;
      push6(8'hA5, 8'h13, 8'h11, 8'h11, 8'h22, 8'h22);
      i_enable = 1'b1;
      wait_busy(1'b1, 100, "overrun_start");
      n = 0;
      while (!o_overrun && n < 200) begin
         @(negedge i_clock);
         n++;
      end
      check("overrun_set_cycles", n, 20);
      check("overrun_flag", {31'd0, o_overrun}, 32'd1);
      check("overrun_busy", {31'd0, o_busy}, 32'd1);
      i_enable = 1'b0;
      @(negedge i_clock);
      check("overrun_cleared", {31'd0, o_overrun}, 32'd0);
      wait_busy(1'b0, 4000, "overrun_done");
      exp_fc++;
      check("frame_count", {16'd0, o_frame_count}, {16'd0, exp_fc});
      check("overrun_stays_clear", {31'd0, o_overrun}, 32'd0);
      ser_gap = 10;

      // Asynchronous reset at byte index 3
      @(negedge i_clock);
      i_ch1_data = 16'hBEEF;
      i_ch2_data = 16'hCAFE;
      push6(8'hA5, 8'h17, 8'hBE, 8'hEF, 8'hCA, 8'hFE);
      i_enable = 1'b1;
      wait_busy(1'b1, 100, "abort_start");
      i_enable = 1'b0;
      sends = 0;
      n = 0;
      while (sends < 4 && n < 2000) begin
         @(negedge i_clock);
         if (o_send) sends++;
         n++;
      end
      check("abort_sends_before", sends, 4);
      @(posedge i_clock);
      #2 i_reset = 1'b0;
      #1;
      check("abort_send",    {31'd0, o_send},    32'd0);
      check("abort_data",    {24'd0, o_data},    32'd0);
      check("abort_busy",    {31'd0, o_busy},    32'd0);
      check("abort_overrun", {31'd0, o_overrun}, 32'd0);
      check("abort_fcount",  {16'd0, o_frame_count}, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge i_clock);
      i_reset = 1'b1;
      sends = 0;
      repeat (30) begin
         @(negedge i_clock);
         if (o_send) sends++;
      end
      check("abort_no_send_after", sends, 0);
      exp_fc = '0;
      push6(8'hA5, 8'h03, 8'hBE, 8'hEF, 8'hCA, 8'hFE);
      run_frame(16'hBEEF, 16'hCAFE, 1'b0, 1'b0);

      repeat (5) @(negedge i_clock);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adc_frame_scheduler.md
Name: adc_frame_scheduler

Overview:
- Sequences periodic transmission of ZmodADC1410 controller samples over the byte-serial UART block.
- On each sample-period tick: latches channel 1 and channel 2 sample words, then drives a 6-byte frame (sync, status, CH1 H/L, CH2 H/L) through the serial send/ready handshake.
- Replaces the ad-hoc tick counter in the top level.
- Sits between the ADC controller outputs and the serial transmitter, in the system clock domain.

Parameters:
- DATA_SIZE, 16, ADC output word width; must be 16.
- BYTE_SIZE, 8, serial byte width.
- PERIOD_COUNT, 31000000, clocks per sample-period tick; minimum 16.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  tick generation enable; level.
- i_ch1_data  in  DATA_SIZE  ADC channel 1 sample word.
- i_ch2_data  in  DATA_SIZE  ADC channel 2 sample word.
- i_ch1_empty  in  1  channel 1 FIFO empty; 1 = sample invalid.
- i_ch2_empty  in  1  channel 2 FIFO empty; 1 = sample invalid.
- i_ready  in  1  serial transmitter idle / ready.
- o_send  out  1  one-cycle byte-send strobe.
- o_data  out  BYTE_SIZE  byte presented to the serial transmitter.
- o_busy  out  1  frame in progress.
- o_overrun  out  1  sticky: a tick arrived while a frame was in progress.
- o_frame_count  out  16  completed frames; wraps 16'hFFFF to 0.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_send=0, o_data=0, o_busy=0, o_overrun=0, o_frame_count=0.
  - Period counter = 0, byte index = 0, latched samples = 0, state = IDLE.
- Period counter:
  - While i_enable=1: counts 0..PERIOD_COUNT-1; tick is a 1-cycle pulse when the count equals PERIOD_COUNT-1, then the count wraps to 0.
  - While i_enable=0: counter is held at 0, no ticks, o_overrun cleared.
- State machine (IDLE, CAPTURE, SEND, ACK, NEXT):
  - IDLE: on tick -> CAPTURE.
  - CAPTURE, 1 cycle:
    - Latch i_ch1_data and i_ch2_data.
    - Latch v1 = ~i_ch1_empty and v2 = ~i_ch2_empty.
    - Byte index = 0; o_busy=1 from this cycle on.
    - -> SEND.
  - SEND: wait for i_ready=1. o_data = frame byte[index], stable from SEND entry until ACK exit. When i_ready=1: o_send=1 for exactly one cycle, -> ACK.
  - ACK: wait for i_ready=0 (transmitter acceptance) -> NEXT. No timeout.
  - NEXT:
    - index < 5: index+1 -> SEND.
    - index = 5: o_frame_count+1, o_busy=0 -> IDLE.
- Frame byte order:
  - 0: SYNC_BYTE.
  - 1: {o_frame_count[5:0], v2, v1}.
  - 2: CH1[15:8].
  - 3: CH1[7:0].
  - 4: CH2[15:8].
  - 5: CH2[7:0].
  - An invalid channel sends 8'h00 for both of its bytes.
- Tick latency: tick to first o_send is 2 cycles if i_ready=1 (CAPTURE, SEND).
- o_send is never asserted outside SEND and never on two consecutive cycles.
- Tick while not IDLE:
  - Tick is dropped and o_overrun set to 1; it stays set until i_enable=0 or reset.
  - Period counter is unaffected.
- Tick in the same cycle as NEXT at index 5: counts as an overrun and is dropped. The frame still completes.
- i_enable falling mid-frame: the current frame completes; no new ticks occur.
- Samples are latched only in CAPTURE; input changes during a frame do not alter transmitted bytes.
- Reset mid-frame: immediate return to the reset state. No further o_send; the partial frame is abandoned.

Test Plan:
- Basic frame: PERIOD_COUNT=20, i_enable=1, ch1=16'h1234, ch2=16'hABCD, both empty=0, serial model with ready dropping 1 cycle after send and returning after 10 cycles -> bytes A5, 03, 12, 34, AB, CD; o_frame_count=1; first o_send 2 cycles after tick.
- Invalid channel: i_ch2_empty=1, ch1=16'h00FF -> bytes A5, 05 (frame_count=1, v1=1), 00, FF, 00, 00.
- Overrun: PERIOD_COUNT=20, serial ready returns after 40 cycles -> o_overrun=1 after the second tick; first frame intact; dropping i_enable clears o_overrun.
- Stall: i_ready held 0 for 500 cycles in SEND -> o_send stays 0 and o_data stays A5; on release, exactly one o_send pulse.
- Sample stability: change ch1 every cycle during a frame -> transmitted bytes equal the value at CAPTURE.
- Asynchronous reset while at byte index 3 -> all outputs 0 immediately, no o_send afterwards; after release and the next tick, a frame restarts with byte A5 and status 8'h03.
